req_arbiter_8: RTL



---
 rtl/req_arbiter_8.sv | 82 ++++++++
 1 files changed

// File: rtl/req_arbiter_8.sv
// Eight-way request arbiter for a shared resource. Grants one requester at a time
// (fixed or round-robin priority) and holds it until release or hold timeout.
module req_arbiter_8 #(
  parameter int RR_EN    = 1,
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] req,
  output logic [7:0] grant,
  output logic [2:0] grant_idx,
  output logic       grant_valid,
  output logic       timed_out
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t     state;
  logic [7:0] hold_cnt;
  logic [2:0] last_idx;
  logic [2:0] base;
  logic [2:0] cand;
  logic [2:0] winner;

  // Search starts just below base and wraps down to base itself; fixed mode
  // pins base at 0 so the order is always 7..0.
  always_comb begin
    base   = (RR_EN != 0) ? last_idx : 3'd0;
    cand   = 3'd0;
    winner = 3'd0;
    for (int k = 8; k >= 1; k--) begin
      cand = base - 3'(k);
      if (req[cand]) winner = cand;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      grant       <= 8'h00;
      grant_idx   <= 3'd0;
      grant_valid <= 1'b0;
      timed_out   <= 1'b0;
      hold_cnt    <= 8'd0;
      last_idx    <= 3'd0;
    end else begin
      timed_out <= 1'b0;
      case (state)
        IDLE: begin
          if (en && (req != 8'h00)) begin
            state       <= GRANT;
            grant       <= 8'b1 << winner;
            grant_idx   <= winner;
            grant_valid <= 1'b1;
            hold_cnt    <= 8'd0;
          end
        end
        GRANT: begin
          if (!req[grant_idx]) begin
            state       <= IDLE;
            grant       <= 8'h00;
            grant_valid <= 1'b0;
            last_idx    <= grant_idx;
          end else if (hold_cnt == HOLD_LAST) begin
            state       <= IDLE;
            grant       <= 8'h00;
            grant_valid <= 1'b0;
            timed_out   <= 1'b1;
            last_idx    <= grant_idx;
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
